// File: rtl/qupls_io_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// qupls_io_sequencer_pkg
// Shared types for the uncached I/O sequencer: the queued request record,
// the sequencer state encoding, default timeout and the load-result helper.
// The IO_AWID / IO_TAGW widths size the stored request record; the top-level
// AWID / TAGW parameters must not exceed them.
// ---------------------------------------------------------------------------
package qupls_io_sequencer_pkg;

    localparam int IO_TMO  = 255;
    localparam int IO_AWID = 32;
    localparam int IO_TAGW = 6;

    typedef struct packed {
        logic               store;
        logic [IO_TAGW-1:0] tag;
        logic [IO_AWID-1:0] adr;
        logic [7:0]         sel;
        logic [63:0]        dat;
    } io_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        BUS  = 2'd2,
        RESP = 2'd3
    } io_seq_state_t;

    // Data returned to the ROB: stores and errored loads report zero.
    function automatic logic [63:0] load_result(input logic        store,
                                                input logic        err,
                                                input logic [63:0] dati);
        if (store || err) begin
            return 64'd0;
        end else begin
            return dati;
        end
    endfunction

endpackage

// File: rtl/qupls_io_req_fifo.sv
// ---------------------------------------------------------------------------
// qupls_io_req_fifo
// Circular request queue for the I/O sequencer. Pointers carry a wrap bit so
// full and empty are distinguished without a separate counter.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   enq         write enq_data at the tail (ignored while full or flushing)
//   enq_data    request record to store
//   deq         retire the head (ignored while empty)
//   flush_all   discard every entry (tail := head)
//   flush_keep  discard every entry except the head (tail := head + 1)
//   full, empty queue status
//   head        record at the head of the queue
// ---------------------------------------------------------------------------
module qupls_io_req_fifo
    import qupls_io_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    enq,
    input  io_req_t enq_data,
    input  logic    deq,
    input  logic    flush_all,
    input  logic    flush_keep,
    output logic    full,
    output logic    empty,
    output io_req_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [PW:0] wptr_r;
    logic [PW:0] rptr_r;
    io_req_t     mem_r [DEPTH];
    logic        enq_ok_s;
    logic        deq_ok_s;

    assign empty    = (wptr_r == rptr_r);
    assign full     = (wptr_r[PW-1:0] == rptr_r[PW-1:0]) && (wptr_r[PW] != rptr_r[PW]);
    assign head     = mem_r[rptr_r[PW-1:0]];
    assign enq_ok_s = enq && !full && !flush_all && !flush_keep;
    assign deq_ok_s = deq && !empty;

    // Head/tail pointer update; a flush rewrites the tail relative to the head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r <= {(PW+1){1'b0}};
            rptr_r <= {(PW+1){1'b0}};
        end else begin
            if (deq_ok_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            if (flush_all) begin
                wptr_r <= rptr_r;
            end else if (flush_keep && !empty) begin
                wptr_r <= rptr_r + PTR_ONE;
            end else if (enq_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end else begin
                wptr_r <= wptr_r;
            end
        end
    end

    // Entry storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (enq_ok_s) begin
            mem_r[wptr_r[PW-1:0]] <= enq_data;
        end
    end

endmodule

// File: rtl/qupls_io_sequencer.sv
// ---------------------------------------------------------------------------
// qupls_io_sequencer
// Uncached I/O back end. Queues I/O memory ops, waits until the head op is
// the oldest uncommitted instruction, runs exactly one bus transaction for
// it and reports completion (load data / error) to the ROB.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_*                    op offered by the memory issue stage
//   oldest_valid/oldest_tag  ROB head identification
//   flush                    pipeline flush, discards unissued ops
//   io_*                     uncached bus master port
//   resp_*                   one-cycle completion report to the ROB
// ---------------------------------------------------------------------------
module qupls_io_sequencer
    import qupls_io_sequencer_pkg::*;
#(
    parameter int AWID  = IO_AWID,
    parameter int DEPTH = 4,
    parameter int TAGW  = IO_TAGW,
    parameter int TMO   = IO_TMO
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [TAGW-1:0] req_tag,
    input  logic [AWID-1:0] req_adr,
    input  logic [7:0]      req_sel,
    input  logic [63:0]     req_dat,
    input  logic            oldest_valid,
    input  logic [TAGW-1:0] oldest_tag,
    input  logic            flush,
    output logic            io_cyc,
    output logic            io_we,
    output logic [AWID-1:0] io_adr,
    output logic [7:0]      io_sel,
    output logic [63:0]     io_dato,
    input  logic            io_ack,
    input  logic            io_err,
    input  logic [63:0]     io_dati,
    output logic            resp_valid,
    output logic [TAGW-1:0] resp_tag,
    output logic [63:0]     resp_dat,
    output logic            resp_err
);

    localparam int CW = $clog2(TMO + 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

    io_seq_state_t state_r;
    io_seq_state_t state_s;

    io_req_t enq_req_s;
    io_req_t head_s;
    logic    fifo_full_s;
    logic    fifo_empty_s;
    logic    enq_s;
    logic    flush_all_s;
    logic    flush_keep_s;

    logic    tag_match_s;
    logic    start_bus_s;
    logic    bus_ack_s;
    logic    bus_tmo_s;
    logic    finish_s;

    logic [CW-1:0] cnt_r;
    logic [63:0]   hold_dat_r;
    logic          hold_err_r;

    // A flush blocks enqueue in the same cycle, whatever the state.
    assign req_ready = !fifo_full_s && !flush;
    assign enq_s     = req_valid && req_ready;

    assign enq_req_s.store = req_store;
    assign enq_req_s.tag   = IO_TAGW'(req_tag);
    assign enq_req_s.adr   = IO_AWID'(req_adr);
    assign enq_req_s.sel   = req_sel;
    assign enq_req_s.dat   = req_dat;

    assign tag_match_s = oldest_valid && (oldest_tag == TAGW'(head_s.tag));

    qupls_io_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .enq        (enq_s),
        .enq_data   (enq_req_s),
        .deq        (finish_s),
        .flush_all  (flush_all_s),
        .flush_keep (flush_keep_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .head       (head_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-cycle control decode. Once the bus cycle has
    // started the head op is committed to completing, so a flush then only
    // trims the entries behind it.
    always_comb begin
        state_s      = state_r;
        start_bus_s  = 1'b0;
        bus_ack_s    = 1'b0;
        bus_tmo_s    = 1'b0;
        finish_s     = 1'b0;
        flush_all_s  = 1'b0;
        flush_keep_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (flush) begin
                    flush_all_s = 1'b1;
                    state_s     = IDLE;
                end else if (!fifo_empty_s) begin
                    state_s = WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (flush) begin
                    flush_all_s = 1'b1;
                    state_s     = IDLE;
                end else if (tag_match_s) begin
                    start_bus_s = 1'b1;
                    state_s     = BUS;
                end else begin
                    state_s = WAIT;
                end
            end
            BUS: begin
                flush_keep_s = flush;
                if (io_ack) begin
                    bus_ack_s = 1'b1;
                    state_s   = RESP;
                end else if (cnt_r == CNT_LAST) begin
                    bus_tmo_s = 1'b1;
                    state_s   = RESP;
                end else begin
                    state_s = BUS;
                end
            end
            RESP: begin
                flush_keep_s = flush;
                finish_s     = 1'b1;
                state_s      = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Bus master outputs, timeout counter, captured result and ROB report.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_cyc     <= 1'b0;
            io_we      <= 1'b0;
            io_adr     <= {AWID{1'b0}};
            io_sel     <= 8'd0;
            io_dato    <= 64'd0;
            cnt_r      <= {CW{1'b0}};
            hold_dat_r <= 64'd0;
            hold_err_r <= 1'b0;
            resp_valid <= 1'b0;
            resp_tag   <= {TAGW{1'b0}};
            resp_dat   <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            if (start_bus_s) begin
                io_cyc     <= 1'b1;
                io_we      <= head_s.store;
                io_adr     <= AWID'(head_s.adr);
                io_sel     <= head_s.sel;
                io_dato    <= head_s.dat;
                cnt_r      <= {CW{1'b0}};
                hold_dat_r <= 64'd0;
                hold_err_r <= 1'b0;
            end else if (bus_ack_s || bus_tmo_s) begin
                io_cyc     <= 1'b0;
                io_we      <= 1'b0;
                io_adr     <= {AWID{1'b0}};
                io_sel     <= 8'd0;
                io_dato    <= 64'd0;
                // A timeout reports as an error with no data.
                hold_dat_r <= bus_ack_s ? load_result(io_we, io_err, io_dati) : 64'd0;
                hold_err_r <= bus_ack_s ? io_err : 1'b1;
            end else if (state_r == BUS) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else if (finish_s) begin
                cnt_r <= {CW{1'b0}};
            end

            if (finish_s) begin
                resp_valid <= 1'b1;
                resp_tag   <= TAGW'(head_s.tag);
                resp_dat   <= hold_dat_r;
                resp_err   <= hold_err_r;
            end else begin
                resp_valid <= 1'b0;
                resp_tag   <= {TAGW{1'b0}};
                resp_dat   <= 64'd0;
                resp_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qupls_io_sequencer.sv
// ---------------------------------------------------------------------------
// tb_qupls_io_sequencer
// Directed self-checking bench for qupls_io_sequencer. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_qupls_io_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [5:0]  req_tag;
    logic [31:0] req_adr;
    logic [7:0]  req_sel;
    logic [63:0] req_dat;
    logic        oldest_valid;
    logic [5:0]  oldest_tag;
    logic        flush;
    logic        io_cyc;
    logic        io_we;
    logic [31:0] io_adr;
    logic [7:0]  io_sel;
    logic [63:0] io_dato;
    logic        io_ack;
    logic        io_err;
    logic [63:0] io_dati;
    logic        resp_valid;
    logic [5:0]  resp_tag;
    logic [63:0] resp_dat;
    logic        resp_err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    qupls_io_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_tag      (req_tag),
        .req_adr      (req_adr),
        .req_sel      (req_sel),
        .req_dat      (req_dat),
        .oldest_valid (oldest_valid),
        .oldest_tag   (oldest_tag),
        .flush        (flush),
        .io_cyc       (io_cyc),
        .io_we        (io_we),
        .io_adr       (io_adr),
        .io_sel       (io_sel),
        .io_dato      (io_dato),
        .io_ack       (io_ack),
        .io_err       (io_err),
        .io_dati      (io_dati),
        .resp_valid   (resp_valid),
        .resp_tag     (resp_tag),
        .resp_dat     (resp_dat),
        .resp_err     (resp_err)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_enq(input logic st, input logic [5:0] tag, input logic [31:0] adr,
                          input logic [7:0] sel, input logic [63:0] dat);
        req_valid = 1'b1;
        req_store = st;
        req_tag   = tag;
        req_adr   = adr;
        req_sel   = sel;
        req_dat   = dat;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (io_cyc === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_resp(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (resp_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Release the head with tag, check the bus request, ack it, check the report.
    task automatic do_txn(input string nm, input logic [5:0] tag, input logic [31:0] exp_adr,
                          input logic exp_we, input logic [63:0] ack_dat, input logic ack_err,
                          input logic [63:0] exp_rdat, input logic exp_rerr);
        bit seen;
        oldest_valid = 1'b1;
        oldest_tag   = tag;
        wait_cyc(20, seen);
        total_cnt++;
        if (seen !== 1'b1) $display("FAIL %s_cyc: got no io_cyc, expected io_cyc=1", nm);
        else pass_cnt++;
        total_cnt++;
        if (io_adr !== exp_adr) $display("FAIL %s_adr: got %h expected %h", nm, io_adr, exp_adr);
        else pass_cnt++;
        total_cnt++;
        if (io_we !== exp_we) $display("FAIL %s_we: got %b expected %b", nm, io_we, exp_we);
        else pass_cnt++;
        io_ack  = 1'b1;
        io_err  = ack_err;
        io_dati = ack_dat;
        step();
        io_ack  = 1'b0;
        io_err  = 1'b0;
        io_dati = 64'd0;
        wait_resp(20, seen);
        total_cnt++;
        if (seen !== 1'b1) $display("FAIL %s_resp: got no resp_valid, expected resp_valid=1", nm);
        else pass_cnt++;
        total_cnt++;
        if (resp_tag !== tag) $display("FAIL %s_tag: got %0d expected %0d", nm, resp_tag, tag);
        else pass_cnt++;
        total_cnt++;
        if (resp_dat !== exp_rdat) $display("FAIL %s_dat: got %h expected %h", nm, resp_dat, exp_rdat);
        else pass_cnt++;
        total_cnt++;
        if (resp_err !== exp_rerr) $display("FAIL %s_err: got %b expected %b", nm, resp_err, exp_rerr);
        else pass_cnt++;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", req_ready);
        else pass_cnt++;
        total_cnt++;
        if ({io_cyc, io_we, io_adr, io_sel, io_dato} !== 106'd0)
            $display("FAIL reset_bus: got cyc=%b we=%b adr=%h expected all 0", io_cyc, io_we, io_adr);
        else pass_cnt++;
        total_cnt++;
        if ({resp_valid, resp_tag, resp_dat, resp_err} !== 72'd0)
            $display("FAIL reset_resp: got valid=%b tag=%0d dat=%h expected all 0", resp_valid, resp_tag, resp_dat);
        else pass_cnt++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_load();
        oldest_valid = 1'b1;
        oldest_tag   = 6'd5;
        do_enq(1'b0, 6'd5, 32'hFFD0_0000, 8'hFF, 64'd0);
        step();
        total_cnt++;
        if (io_cyc !== 1'b0) $display("FAIL load_wait_cyc: got %b expected 0", io_cyc);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({io_cyc, io_we, io_adr, io_sel} !== {1'b1, 1'b0, 32'hFFD0_0000, 8'hFF})
            $display("FAIL load_bus: got cyc=%b we=%b adr=%h sel=%h expected 1 0 ffd00000 ff", io_cyc, io_we, io_adr, io_sel);
        else pass_cnt++;
        step();
        total_cnt++;
        if (io_cyc !== 1'b1) $display("FAIL load_hold: got %b expected 1", io_cyc);
        else pass_cnt++;
        io_ack  = 1'b1;
        io_dati = 64'h1234;
        step();
        io_ack  = 1'b0;
        io_dati = 64'd0;
        total_cnt++;
        if ({io_cyc, resp_valid} !== 2'b00) $display("FAIL load_drop: got cyc=%b resp=%b expected 0 0", io_cyc, resp_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if ({resp_valid, resp_tag, resp_dat, resp_err} !== {1'b1, 6'd5, 64'h1234, 1'b0})
            $display("FAIL load_resp: got v=%b tag=%0d dat=%h err=%b expected 1 5 1234 0", resp_valid, resp_tag, resp_dat, resp_err);
        else pass_cnt++;
        step();
        total_cnt++;
        if (resp_valid !== 1'b0) $display("FAIL load_pulse: got %b expected 0", resp_valid);
        else pass_cnt++;
    endtask

    task automatic test_store_wait();
        bit any_cyc;
        bit seen;
        oldest_tag = 6'd2;
        do_enq(1'b1, 6'd3, 32'hFFD0_0008, 8'h0F, 64'hDEAD_BEEF_CAFE_F00D);
        any_cyc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (io_cyc !== 1'b0) any_cyc = 1'b1;
            step();
        end
        total_cnt++;
        if (any_cyc !== 1'b0) $display("FAIL store_not_oldest: got io_cyc=1 expected 0");
        else pass_cnt++;
        oldest_tag = 6'd3;
        wait_cyc(10, seen);
        total_cnt++;
        if ({seen, io_we, io_sel, io_dato} !== {1'b1, 1'b1, 8'h0F, 64'hDEAD_BEEF_CAFE_F00D})
            $display("FAIL store_bus: got seen=%b we=%b sel=%h dato=%h expected 1 1 0f deadbeefcafef00d", seen, io_we, io_sel, io_dato);
        else pass_cnt++;
        io_ack  = 1'b1;
        io_dati = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        io_ack  = 1'b0;
        io_dati = 64'd0;
        wait_resp(10, seen);
        total_cnt++;
        if ({seen, resp_tag, resp_dat, resp_err} !== {1'b1, 6'd3, 64'd0, 1'b0})
            $display("FAIL store_resp: got v=%b tag=%0d dat=%h err=%b expected 1 3 0 0", seen, resp_tag, resp_dat, resp_err);
        else pass_cnt++;
        step();
    endtask

    task automatic test_full_wrap();
        logic [5:0] tag;
        oldest_tag = 6'd9;
        for (int i = 0; i < 4; i++) begin
            tag = 6'd10 + 6'(i);
            do_enq(1'b0, tag, 32'hFFD0_0100 + 32'(8 * i), 8'hFF, 64'd0);
            total_cnt++;
            if (req_ready !== (i < 3)) $display("FAIL full_ready%0d: got %b expected %b", i, req_ready, (i < 3));
            else pass_cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            tag = 6'd10 + 6'(i);
            do_txn($sformatf("wrap%0d", i), tag, 32'hFFD0_0100 + 32'(8 * i), 1'b0,
                   64'h1000 + 64'(i), 1'b0, 64'h1000 + 64'(i), 1'b0);
            total_cnt++;
            if (req_ready !== 1'b1) $display("FAIL wrap_ready%0d: got %b expected 1", i, req_ready);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
        bit seen;
        bit held;
        oldest_tag = 6'd20;
        do_enq(1'b0, 6'd20, 32'hFFD0_0200, 8'hFF, 64'd0);
        do_enq(1'b0, 6'd21, 32'hFFD0_0208, 8'hFF, 64'd0);
        wait_cyc(10, seen);
        held = seen;
        for (int i = 0; i < 254; i++) begin
            step();
            if (io_cyc !== 1'b1) held = 1'b0;
        end
        total_cnt++;
        if (held !== 1'b1) $display("FAIL tmo_hold: got io_cyc dropped early expected held 255 cycles");
        else pass_cnt++;
        step();
        total_cnt++;
        if (io_cyc !== 1'b0) $display("FAIL tmo_drop: got %b expected 0", io_cyc);
        else pass_cnt++;
        wait_resp(10, seen);
        total_cnt++;
        if ({seen, resp_tag, resp_dat, resp_err} !== {1'b1, 6'd20, 64'd0, 1'b1})
            $display("FAIL tmo_resp: got v=%b tag=%0d dat=%h err=%b expected 1 20 0 1", seen, resp_tag, resp_dat, resp_err);
        else pass_cnt++;
        step();
        do_txn("after_tmo", 6'd21, 32'hFFD0_0208, 1'b0, 64'hA5A5, 1'b0, 64'hA5A5, 1'b0);
        do_enq(1'b0, 6'd22, 32'hFFD0_0210, 8'hFF, 64'd0);
        do_txn("load_err", 6'd22, 32'hFFD0_0210, 1'b0, 64'h5A5A, 1'b1, 64'd0, 1'b1);
    endtask

    task automatic test_flush_wait();
        bit any_act;
        oldest_tag = 6'd30;
        do_enq(1'b0, 6'd31, 32'hFFD0_0300, 8'hFF, 64'd0);
        do_enq(1'b0, 6'd32, 32'hFFD0_0308, 8'hFF, 64'd0);
        do_enq(1'b0, 6'd33, 32'hFFD0_0310, 8'hFF, 64'd0);
        step();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_tag   = 6'd35;
        req_adr   = 32'hFFD0_0318;
        #1;
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL flush_ready: got %b expected 0", req_ready);
        else pass_cnt++;
        step();
        flush      = 1'b0;
        req_valid  = 1'b0;
        oldest_tag = 6'd31;
        any_act    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (io_cyc !== 1'b0 || resp_valid !== 1'b0) any_act = 1'b1;
            step();
        end
        total_cnt++;
        if (any_act !== 1'b0) $display("FAIL flush_wait_quiet: got bus/resp activity expected none");
        else pass_cnt++;
        do_enq(1'b0, 6'd34, 32'hFFD0_0320, 8'hFF, 64'd0);
        do_txn("post_flush", 6'd34, 32'hFFD0_0320, 1'b0, 64'h3434, 1'b0, 64'h3434, 1'b0);
        oldest_tag = 6'd35;
        any_act    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (io_cyc !== 1'b0) any_act = 1'b1;
            step();
        end
        total_cnt++;
        if (any_act !== 1'b0) $display("FAIL flush_drop_req: got io_cyc=1 expected 0");
        else pass_cnt++;
    endtask

    task automatic test_flush_bus();
        bit seen;
        bit any_cyc;
        oldest_tag = 6'd40;
        do_enq(1'b0, 6'd40, 32'hFFD0_0400, 8'hFF, 64'd0);
        do_enq(1'b0, 6'd41, 32'hFFD0_0408, 8'hFF, 64'd0);
        do_enq(1'b0, 6'd42, 32'hFFD0_0410, 8'hFF, 64'd0);
        wait_cyc(10, seen);
        flush = 1'b1;
        step();
        flush = 1'b0;
        total_cnt++;
        if ({seen, io_cyc, io_adr} !== {1'b1, 1'b1, 32'hFFD0_0400})
            $display("FAIL flush_bus_keep: got seen=%b cyc=%b adr=%h expected 1 1 ffd00400", seen, io_cyc, io_adr);
        else pass_cnt++;
        io_ack  = 1'b1;
        io_dati = 64'h4040;
        step();
        io_ack  = 1'b0;
        io_dati = 64'd0;
        wait_resp(10, seen);
        total_cnt++;
        if ({seen, resp_tag, resp_dat} !== {1'b1, 6'd40, 64'h4040})
            $display("FAIL flush_bus_resp: got v=%b tag=%0d dat=%h expected 1 40 4040", seen, resp_tag, resp_dat);
        else pass_cnt++;
        step();
        any_cyc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            oldest_tag = (i < 10) ? 6'd41 : 6'd42;
            if (io_cyc !== 1'b0 || resp_valid !== 1'b0) any_cyc = 1'b1;
            step();
        end
        total_cnt++;
        if (any_cyc !== 1'b0) $display("FAIL flush_bus_discard: got activity for flushed ops expected none");
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit any_act;
        oldest_tag = 6'd50;
        do_enq(1'b0, 6'd50, 32'hFFD0_0500, 8'hFF, 64'd0);
        wait_cyc(10, seen);
        total_cnt++;
        if (seen !== 1'b1) $display("FAIL rst_mid_start: got no io_cyc expected 1");
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({io_cyc, req_ready} !== 2'b01) $display("FAIL rst_mid_async: got cyc=%b ready=%b expected 0 1", io_cyc, req_ready);
        else pass_cnt++;
        step();
        step();
        rst     = 1'b0;
        any_act = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (io_cyc !== 1'b0 || resp_valid !== 1'b0) any_act = 1'b1;
            step();
        end
        total_cnt++;
        if (any_act !== 1'b0) $display("FAIL rst_mid_quiet: got bus/resp activity after reset expected none");
        else pass_cnt++;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_store    = 1'b0;
        req_tag      = 6'd0;
        req_adr      = 32'd0;
        req_sel      = 8'd0;
        req_dat      = 64'd0;
        oldest_valid = 1'b0;
        oldest_tag   = 6'd0;
        flush        = 1'b0;
        io_ack       = 1'b0;
        io_err       = 1'b0;
        io_dati      = 64'd0;
        test_reset();
        test_load();
        test_store_wait();
        test_full_wrap();
        test_timeout();
        test_flush_wait();
        test_flush_bus();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/qupls_io_sequencer.md
Name: qupls_io_sequencer

Overview:
- Back end for memory ops that the decoder flags as I/O (cache attribute field zero, i.e. uncached).
- Queues these ops from the memory issue stage and holds each until it is the oldest uncommitted instruction.
- Performs exactly one non-speculative, in-order bus transaction per op, then returns the load data or store completion to the ROB.
- Sits beside the data-cache load/store unit and owns the uncached I/O bus master port.

Parameters:
- AWID, 32, I/O address width.
- DEPTH, 4, request queue entries (power of 2, min 2).
- TAGW, 6, ROB tag width.
- TMO, 255, bus timeout in cycles before an error is forced.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_valid  input  1  I/O op offered
- req_ready  output  1  queue can accept
- req_store  input  1  1=store, 0=load
- req_tag  input  TAGW  ROB tag of op
- req_adr  input  AWID  byte address
- req_sel  input  8  byte lane selects
- req_dat  input  64  store data
- oldest_valid  input  1  oldest_tag is meaningful
- oldest_tag  input  TAGW  ROB head tag
- flush  input  1  pipeline flush; discard unissued entries
- io_cyc  output  1  bus cycle active
- io_we  output  1  bus write
- io_adr  output  AWID  bus address
- io_sel  output  8  bus byte selects
- io_dato  output  64  bus write data
- io_ack  input  1  bus acknowledge
- io_err  input  1  bus error (valid with ack)
- io_dati  input  64  bus read data
- resp_valid  output  1  one-cycle completion pulse
- resp_tag  output  TAGW  completed tag
- resp_dat  output  64  load data (0 for stores)
- resp_err  output  1  bus error or timeout

Behaviour:
- Reset: queue empty, state IDLE, req_ready=1, every other output 0, timeout counter 0.
- Queue: circular FIFO with DEPTH entries; read/write pointers of log2(DEPTH)+1 bits with wrap bit.
  - full when indices are equal and wrap bits differ; req_ready=!full.
  - Enqueue on req_valid&&req_ready; accepting while full is impossible by construction.
  - Simultaneous enqueue and dequeue while full is not allowed (ready is low).
  - Simultaneous enqueue and dequeue while empty: entry is enqueued; dequeue only happens from a non-empty head.
- FSM:
  - IDLE: if queue is non-empty and not flush -> WAIT.
  - WAIT: when oldest_valid and oldest_tag==head.tag, drive io_cyc=1, io_we=head.store, io_adr/io_sel/io_dato from head on the next edge -> BUS. Head stays in WAIT indefinitely otherwise.
  - BUS: bus signals held stable; the timeout counter increments each cycle.
    - On io_ack: capture io_dati (loads), capture io_err, drop io_cyc the same edge -> RESP.
    - If the counter reaches TMO without ack: drop io_cyc, resp_err=1, resp_dat=0 -> RESP.
  - RESP: resp_valid=1 for exactly one cycle with head tag; dequeue head; counter cleared -> IDLE.
- Response latency: minimum 3 cycles from the oldest match to resp_valid (WAIT->BUS, ack, RESP).
- Flush:
  - In IDLE/WAIT: all entries discarded (write pointer := read pointer), state -> IDLE, no response.
  - In BUS/RESP: the in-flight transaction completes and its response is still emitted (side effects are irreversible); remaining entries are discarded and enqueue is blocked that cycle.
- Flush in the same cycle as req_valid: the request is dropped (req_ready=0 during flush).
- Stores: resp_dat=0. Loads with io_err: resp_dat=0, resp_err=1.
- rst asserted mid-transaction: io_cyc drops immediately (async), queue cleared, no response.

Decomposition:
- QuplsPkg gets:
  - io_req_t struct (store, tag, adr, sel, dat).
  - io_seq_state_t enum (IDLE, WAIT, BUS, RESP).
  - IO_TMO default constant.
- One sub-module, qupls_io_req_fifo: the parameterised FIFO with full/empty and flush-discard.

Test Plan:
- Load at 0xFFD0_0000 tag 5, oldest_tag=5: io_cyc rises 1 cycle after WAIT, ack with dati=0x1234 after 2 cycles -> resp_valid with tag 5, dat 0x1234, err 0.
- Store tag 3 enqueued while oldest_tag=2 for 10 cycles: no io_cyc. oldest_tag changes to 3 -> io_we=1, io_dato=req data; ack -> resp_dat 0, err 0.
- Enqueue 4 ops: req_ready=0 after the 4th; complete one -> req_ready=1. Ops issue in tags 10, 11, 12, 13 order across a pointer wrap.
- No ack for 255 cycles -> io_cyc drops, resp_err=1 for that tag; the next entry proceeds normally.
- Flush with 3 entries in WAIT: no bus cycle and no response, queue empty. Flush during BUS: that op still responds and the other entries are gone.
- Assert rst while io_cyc=1: io_cyc=0 asynchronously, req_ready=1, resp_valid never pulses.
